// File: rtl/seq_divider_if.sv
// Handshake and result bundle for seq_divider.
// SEQ_DIVIDER_DIVU_EN adds the is_unsigned request qualifier.
interface seq_divider_if;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
`ifdef SEQ_DIVIDER_DIVU_EN
  logic        is_unsigned;
`endif
  logic [31:0] hi;
  logic [31:0] lo;
  logic        ready;
  logic        div_zero;
  logic        busy;

  modport master (
    output start, a, b,
`ifdef SEQ_DIVIDER_DIVU_EN
    output is_unsigned,
`endif
    input  hi, lo, ready, div_zero, busy
  );

  modport slave (
    input  start, a, b,
`ifdef SEQ_DIVIDER_DIVU_EN
    input  is_unsigned,
`endif
    output hi, lo, ready, div_zero, busy
  );
endinterface

// File: rtl/seq_divider.sv
// 32-bit MIPS DIV: restoring divider, 33 edges from accepted start to ready.
// Define SEQ_DIVIDER_DIVU_EN to add the is_unsigned (DIVU) request mode.
module seq_divider (
  input  logic          clk,
  input  logic          reset,
  seq_divider_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t      state_reg, state_next;
  logic [4:0]  count_reg, count_next;
  logic [31:0] rem_reg, rem_next;
  logic [31:0] quo_reg, quo_next;
  logic [32:0] dvsr_reg, dvsr_next;
  logic        q_neg_reg, q_neg_next;
  logic        r_neg_reg, r_neg_next;
  logic [31:0] hi_reg, hi_next;
  logic [31:0] lo_reg, lo_next;
  logic        ready_reg, ready_next;
  logic        dz_reg, dz_next;

  logic        op_signed;
  logic [32:0] a_ext, b_ext, a_mag, b_mag;
  logic [32:0] shifted;
  logic [31:0] sub;
  logic        ge;

`ifdef SEQ_DIVIDER_DIVU_EN
  assign op_signed = ~bus.is_unsigned;
`else
  assign op_signed = 1'b1;
`endif

  // 33-bit magnitudes keep |0x80000000| exact.
  assign a_ext = {op_signed & bus.a[31], bus.a};
  assign b_ext = {op_signed & bus.b[31], bus.b};
  assign a_mag = a_ext[32] ? (33'd0 - a_ext) : a_ext;
  assign b_mag = b_ext[32] ? (33'd0 - b_ext) : b_ext;

  assign shifted = {rem_reg, quo_reg[31]};
  assign ge      = (shifted >= dvsr_reg);
  assign sub     = shifted[31:0] - dvsr_reg[31:0];

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    rem_next   = rem_reg;
    quo_next   = quo_reg;
    dvsr_next  = dvsr_reg;
    q_neg_next = q_neg_reg;
    r_neg_next = r_neg_reg;
    hi_next    = hi_reg;
    lo_next    = lo_reg;
    ready_next = 1'b0;
    dz_next    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          if (bus.b == 32'd0) begin
            ready_next = 1'b1;
            dz_next    = 1'b1;
          end else begin
            // Top magnitude bit (always 0 here) seeds the partial remainder.
            rem_next   = {31'd0, a_mag[32]};
            quo_next   = a_mag[31:0];
            dvsr_next  = b_mag;
            q_neg_next = op_signed & (bus.a[31] ^ bus.b[31]);
            r_neg_next = op_signed & bus.a[31];
            count_next = 5'd0;
            state_next = RUN;
          end
        end
      end
      RUN: begin
        if (ge) begin
          rem_next = sub;
          quo_next = {quo_reg[30:0], 1'b1};
        end else begin
          rem_next = shifted[31:0];
          quo_next = {quo_reg[30:0], 1'b0};
        end
        count_next = count_reg + 5'd1;
        if (count_reg == 5'd31) state_next = FIX;
      end
      FIX: begin
        lo_next    = q_neg_reg ? (32'd0 - quo_reg) : quo_reg;
        hi_next    = r_neg_reg ? (32'd0 - rem_reg) : rem_reg;
        ready_next = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      count_reg <= 5'd0;
      rem_reg   <= 32'd0;
      quo_reg   <= 32'd0;
      dvsr_reg  <= 33'd0;
      q_neg_reg <= 1'b0;
      r_neg_reg <= 1'b0;
      hi_reg    <= 32'd0;
      lo_reg    <= 32'd0;
      ready_reg <= 1'b0;
      dz_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      rem_reg   <= rem_next;
      quo_reg   <= quo_next;
      dvsr_reg  <= dvsr_next;
      q_neg_reg <= q_neg_next;
      r_neg_reg <= r_neg_next;
      hi_reg    <= hi_next;
      lo_reg    <= lo_next;
      ready_reg <= ready_next;
      dz_reg    <= dz_next;
    end
  end

  assign bus.hi       = hi_reg;
  assign bus.lo       = lo_reg;
  assign bus.ready    = ready_reg;
  assign bus.div_zero = dz_reg;
  assign bus.busy     = (state_reg == RUN) || (state_reg == FIX);

endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-002 Port: clk  input  1  rising-edge clock.
REQ-003 Port: reset  input  1  asynchronous active-low reset; 0 = reset.
REQ-004 Port: start  input  1  one-cycle request from control unit; sampled only in IDLE.
REQ-005 Port: a  input  32  dividend (rs).
REQ-006 Port: b  input  32  divisor (rt).
REQ-007 Port: hi  output  32  remainder result register.
REQ-008 Port: lo  output  32  quotient result register.
REQ-009 Port: ready  output  1  one-cycle completion pulse.
REQ-010 Port: div_zero  output  1  one-cycle pulse, coincident with ready, when b == 0.
REQ-011 Port: busy  output  1  high in RUN and FIX.

Function
REQ-012 The block SHALL implement the states IDLE, RUN and FIX.
REQ-013 IDLE, start=1, b!=0, edge k: capture |a| and |b|, quotient sign (a[31]^b[31]), remainder sign (a[31]); clear partial remainder; count=0; go to RUN.
REQ-014 RUN: one restoring step per edge (shift remainder/quotient left 1; subtract |b| if result non-negative, set quotient bit 1); 32 steps on edges k+1..k+32; go to FIX after count reaches 31.
REQ-015 FIX, edge k+33: apply sign correction (two's complement); load lo=quotient, hi=remainder; ready=1; go to IDLE.
REQ-016 Total latency SHALL be 33 edges from the start-sampling edge to ready high; ready SHALL be high exactly one cycle.
REQ-017 Semantics SHALL be MIPS DIV: quotient truncates toward zero; remainder takes the sign of the dividend; a = lo*b + hi (mod 2^32).
REQ-018 Operand magnitudes SHALL be computed in 33 bits so |0x80000000| is exact.
REQ-019 0x80000000 / 0xFFFFFFFF SHALL give lo=0x80000000 and hi=0x00000000 (wrap, no flag).
REQ-020 IDLE, start=1, b==0: on the same edge, ready=1 and div_zero=1 for one cycle; hi/lo unchanged; remain in IDLE.
REQ-021 start while busy=1 SHALL be ignored; operands are not re-sampled.
REQ-022 hi/lo SHALL change only on a FIX edge and hold between operations.
REQ-023 A start on the cycle ready is high (state IDLE) SHALL be accepted (back-to-back).
REQ-024 a and b changing during RUN/FIX SHALL not affect the result.

Reset
REQ-025 reset=0 SHALL immediately force IDLE, count=0, hi=0, lo=0, ready=0, div_zero=0, busy=0 and all internal registers 0, including mid-operation.
REQ-026 After reset release, the first rising edge SHALL be able to sample start.

Configuration
REQ-027 Macro SEQ_DIVIDER_DIVU_EN defined: add input port is_unsigned (1 bit), sampled with start; when 1, operands are unsigned magnitudes (no sign capture or fix), giving MIPS DIVU results with the same latency and div_zero rules.
REQ-028 Macro SEQ_DIVIDER_DIVU_EN undefined: no is_unsigned port; signed DIV only.

Verification
REQ-029 a=7, b=2, start -> after 33 edges ready=1 for one cycle, lo=0x00000003, hi=0x00000001, div_zero=0.
REQ-030 a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; a=7, b=0xFFFFFFFE -> lo=0xFFFFFFFD, hi=0x00000001.
REQ-031 Prior lo=0x11, hi=0x22; a=5, b=0, start -> next edge ready=1, div_zero=1; lo=0x11, hi=0x22 unchanged; busy stays 0.
REQ-032 a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0; a=0x80000000, b=1 -> lo=0x80000000, hi=0.
REQ-033 start with a=100, b=7; second start at edge k+10 with a=9, b=3 -> single ready at k+33, lo=14, hi=2; start during the ready cycle with a=9, b=3 -> ready 33 edges later, lo=3, hi=0.
REQ-034 reset=0 at edge k+15 of a division -> outputs 0 immediately, no ready pulse; new division after release completes normally in 33 edges.
